ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the RV32I pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Performs ALU operations, load/store address generation and link-value computation. Forwards results to the EX/MEM register.
- Shifts run on a multi-cycle step shifter. While a shift is in progress, the stage raises stallreq_o to ctrl. Ctrl then freezes IF..ID/EX, so this stage's inputs stay stable.

Parameters:
- SHIFT_STEP, 8, maximum shift distance applied per cycle (power of 2, range 1..16).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high (`RstEnable)
- rdy  in  1  global ready; 0 freezes all state
- stall_sign  in  `StallBus  ctrl stall vector; bit 3 = EX held by a downstream stage
- opcode_i  in  `OpcodeBus  opcode from ID/EX
- funct3_i  in  `FunctBus3
- funct7_i  in  `FunctBus7
- reg1_i  in  `RegBus  operand 1 (rs1 value, or pc for JAL/JALR/AUIPC)
- reg2_i  in  `RegBus  operand 2 (rs2 value or immediate; store data for STORE)
- offset_i  in  `RegBus  load/store immediate offset
- wd_i  in  `RegAddrBus  destination register
- wreg_i  in  1  write enable
- wd_o  out  `RegAddrBus
- wreg_o  out  1
- wdata_o  out  `RegBus  result
- mem_opcode_o  out  `OpcodeBus  LOAD/STORE or `NON_OP
- mem_funct3_o  out  `FunctBus3  access width/sign
- mem_addr_o  out  `RegBus  reg1_i + offset_i
- mem_data_o  out  `RegBus  store data (reg2_i)
- stallreq_o  out  1  shift in progress

Behaviour:
- Reset (rst=1, asynchronous):
  - FSM goes to IDLE; accumulator and remaining count clear.
  - All outputs are 0 (`ZeroWord, `NOPRegAddr, `WriteDisable, `NON_OP, `NON_FUNCT3).
  - A shift in progress is discarded.
- Non-shift operations: combinational, zero latency; wd_o=wd_i, wreg_o=wreg_i.
  - OP/OP_IMM: ADD/SUB (SUB only if opcode=OP and funct7[5]=1), SLT (signed), SLTU (unsigned), XOR, OR, AND.
  - LUI: wdata_o=reg2_i.
  - JAL/JALR/AUIPC: wdata_o=reg1_i+reg2_i.
  - BRANCH: wreg_o=0.
  - LOAD/STORE: mem_addr_o=reg1_i+offset_i (32-bit wrap); mem_data_o=reg2_i. mem_opcode_o and mem_funct3_o pass through.
  - Any other opcode: mem_opcode_o=`NON_OP.
- Shift ops: SLL/SRL/SRA, opcode OP/OP_IMM, funct3 001/101; SRA when funct7[5]=1. Shamt n=reg2_i[4:0]; upper bits are ignored.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, shift decoded, n=0: result is reg1_i in the same cycle; stallreq_o=0; stay IDLE.
  - IDLE, shift decoded, n>0: stallreq_o=1 (combinational); load acc=reg1_i, rem=n; go to SHIFT.
  - SHIFT: each cycle shift acc by min(rem, SHIFT_STEP), subtract that from rem, stallreq_o=1. When rem becomes 0, go to DONE.
  - SRA fills with reg1_i[31]; SLL/SRL fill with 0.
  - DONE: stallreq_o=0; wdata_o=acc; wd_o/wreg_o from inputs.
  - DONE exits to IDLE when stall_sign[3]=0; otherwise stays in DONE holding acc. DONE never restarts on the same instruction.
- Timing: a shift occupies EX for ceil(n/SHIFT_STEP)+2 cycles. With n=31 and SHIFT_STEP=8 that is 6 cycles.
- rdy=0: FSM, acc and rem all freeze; combinational outputs keep tracking the inputs.
- stall_sign[3]=1 during SHIFT: the shift continues to completion, then waits in DONE.
- Inputs are guaranteed stable while stallreq_o=1 or state≠IDLE. Ctrl holds ID/EX in these cases.
- Outputs are sampled externally only when stallreq_o=0.

Optional Feature:
- Macro: EX_BARREL_SHIFT_EN.
  - Defined: shifts are a single-cycle combinational barrel shift; FSM, acc and rem are removed; stallreq_o is tied 0.
  - Undefined: the step-shifter FSM above applies.
- Results must be identical in both builds; only timing differs.

Decomposition:
- defines.v (shared header) holds:
  - opcode and funct3 constants (OP, OP_IMM, LOAD, STORE, LUI, AUIPC, JAL, JALR, BRANCH);
  - shift funct3 codes;
  - FSM state encodings EX_IDLE, EX_SHIFT, EX_DONE;
  - `StallBus.
- One sub-module, ex_shifter, contains the FSM, accumulator and step logic (the barrel path when EX_BARREL_SHIFT_EN is defined).
- ex_stage contains the ALU/address datapath and the output mux.

Test Plan:
- OP ADD reg1=0x7FFFFFFF, reg2=1, wd=5 -> same cycle: wdata_o=0x80000000, wd_o=5, wreg_o=1, stallreq_o=0.
- OP_IMM SRA reg1=0x80000000, shamt=31, SHIFT_STEP=8 -> stallreq_o high for 5 cycles, then wdata_o=0xFFFFFFFF in DONE.
- SLL reg1=1, shamt=0 -> wdata_o=1 immediately, stallreq_o never asserted.
- SRL reg1=0xF0000000, shamt=4, stall_sign[3]=1 held 3 cycles after DONE -> wdata_o=0x0F000000 held stable for all held cycles; IDLE only after release.
- STORE reg1=0xFFFFFFFC, offset=8, reg2=0xA5 -> mem_addr_o=0x00000004, mem_data_o=0xA5, wreg_o=0.
- rst pulsed during SHIFT of SLL shamt=20 -> outputs 0, stallreq_o=0 immediately; after release, a new ADD completes normally.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - RV32I execute-stage opcodes, shift codes, FSM states and shift helper
package ex_stage_pkg;

   localparam logic [6:0] OP         = 7'b0110011;
   localparam logic [6:0] OP_IMM     = 7'b0010011;
   localparam logic [6:0] LOAD       = 7'b0000011;
   localparam logic [6:0] STORE      = 7'b0100011;
   localparam logic [6:0] LUI        = 7'b0110111;
   localparam logic [6:0] AUIPC      = 7'b0010111;
   localparam logic [6:0] JAL        = 7'b1101111;
   localparam logic [6:0] JALR       = 7'b1100111;
   localparam logic [6:0] BRANCH     = 7'b1100011;
   localparam logic [6:0] NON_OP     = 7'b0000000;
   localparam logic [2:0] NON_FUNCT3 = 3'b000;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   localparam int STALL_W = 6;

   typedef enum logic [1:0] {
      EX_IDLE  = 2'd0,
      EX_SHIFT = 2'd1,
      EX_DONE  = 2'd2
   } ex_state_e;

   // Arithmetic right shift goes through a signed temporary so the fill stays the sign bit.
   function automatic logic [31:0] shift_fn(input logic [31:0] v, input logic [4:0] k,
                                            input logic left, input logic arith);
      logic signed [31:0] vs;
      logic signed [31:0] r;
      vs = v;
      r  = vs >>> k;
      if (left)
         return v << k;
      else if (arith)
         return r;
      else
         return v >> k;
   endfunction

endpackage

// File: rtl/ex_shifter.sv
// rtl/ex_shifter.sv - step shifter FSM; EX_BARREL_SHIFT_EN selects a single-cycle barrel shift
module ex_shifter
   import ex_stage_pkg::*;
#(
   parameter int SHIFT_STEP = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        start,
   input  logic        left,
   input  logic        arith,
   input  logic [31:0] value,
   input  logic [4:0]  shamt,
   input  logic        hold,
   output logic [31:0] result,
   output logic        stallreq
);

`ifdef EX_BARREL_SHIFT_EN

   logic unused_ctl;
   assign unused_ctl = ^{clk, rst, rdy, start, hold};
   assign result     = shift_fn(value, shamt, left, arith);
   assign stallreq   = 1'b0;

`else

   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   ex_state_e   state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  rem_q, rem_d;
   logic [4:0]  step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EX_IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
      end else if (rdy) begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
      end
   end

   // IDLE with shamt 0 passes the operand straight through without stalling.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      stallreq = 1'b0;
      result   = value;
      step     = (rem_q > STEP) ? STEP : rem_q;
      case (state_q)
         EX_IDLE: begin
            if (start && (shamt != 5'd0)) begin
               stallreq = 1'b1;
               acc_d    = value;
               rem_d    = shamt;
               state_d  = EX_SHIFT;
            end
         end
         EX_SHIFT: begin
            stallreq = 1'b1;
            acc_d    = shift_fn(acc_q, step, left, arith);
            rem_d    = rem_q - step;
            if (rem_q == step)
               state_d = EX_DONE;
         end
         EX_DONE: begin
            result = acc_q;
            if (!hold)
               state_d = EX_IDLE;
         end
         default: state_d = EX_IDLE;
      endcase
   end

`endif

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage: ALU, address generation, shifts (EX_BARREL_SHIFT_EN option)
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int SHIFT_STEP = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic [STALL_W-1:0] stall_sign,
   input  logic [6:0]         opcode_i,
   input  logic [2:0]         funct3_i,
   input  logic [6:0]         funct7_i,
   input  logic [31:0]        reg1_i,
   input  logic [31:0]        reg2_i,
   input  logic [31:0]        offset_i,
   input  logic [4:0]         wd_i,
   input  logic               wreg_i,
   output logic [4:0]         wd_o,
   output logic               wreg_o,
   output logic [31:0]        wdata_o,
   output logic [6:0]         mem_opcode_o,
   output logic [2:0]         mem_funct3_o,
   output logic [31:0]        mem_addr_o,
   output logic [31:0]        mem_data_o,
   output logic               stallreq_o
);

   logic        is_alu, is_shift;
   logic [31:0] sh_result;
   logic        sh_stall;
   logic        unused_bits;

   assign unused_bits = ^{funct7_i[6], funct7_i[4:0], stall_sign[5:4], stall_sign[2:0]};
   assign is_alu      = (opcode_i == OP) || (opcode_i == OP_IMM);
   assign is_shift    = is_alu && ((funct3_i == F3_SLL) || (funct3_i == F3_SR));

   ex_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .start    (is_shift),
      .left     (funct3_i == F3_SLL),
      .arith    (funct7_i[5]),
      .value    (reg1_i),
      .shamt    (reg2_i[4:0]),
      .hold     (stall_sign[3]),
      .result   (sh_result),
      .stallreq (sh_stall)
   );

   always_comb begin
      wd_o         = wd_i;
      wreg_o       = wreg_i;
      wdata_o      = '0;
      mem_opcode_o = NON_OP;
      mem_funct3_o = NON_FUNCT3;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (opcode_i)
         OP, OP_IMM: begin
            case (funct3_i)
               3'b000:  wdata_o = (opcode_i == OP && funct7_i[5]) ? reg1_i - reg2_i
                                                                   : reg1_i + reg2_i;
               3'b010:  wdata_o = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
               3'b011:  wdata_o = {31'd0, reg1_i < reg2_i};
               3'b100:  wdata_o = reg1_i ^ reg2_i;
               3'b110:  wdata_o = reg1_i | reg2_i;
               3'b111:  wdata_o = reg1_i & reg2_i;
               default: wdata_o = sh_result;
            endcase
         end
         LUI:              wdata_o = reg2_i;
         JAL, JALR, AUIPC: wdata_o = reg1_i + reg2_i;
         BRANCH:           wreg_o  = 1'b0;
         LOAD, STORE: begin
            mem_opcode_o = opcode_i;
            mem_funct3_o = funct3_i;
            mem_addr_o   = reg1_i + offset_i;
            mem_data_o   = reg2_i;
         end
         default: ;
      endcase
      // Reset blanks everything immediately, including a discarded shift.
      if (rst) begin
         wd_o    = '0;
         wreg_o  = 1'b0;
         wdata_o = '0;
         mem_opcode_o = NON_OP;
         mem_funct3_o = NON_FUNCT3;
         mem_addr_o   = '0;
         mem_data_o   = '0;
      end
   end

   assign stallreq_o = sh_stall && !rst;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;

   localparam logic [6:0] T_OP = 7'h33, T_OPI = 7'h13, T_LOAD = 7'h03, T_STORE = 7'h23;
   localparam logic [6:0] T_LUI = 7'h37, T_AUIPC = 7'h17, T_JAL = 7'h6F, T_JALR = 7'h67;
   localparam logic [6:0] T_BR = 7'h63, T_BAD = 7'h7F;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic [5:0]  stall_sign;
   logic [6:0]  opcode_i, funct7_i;
   logic [2:0]  funct3_i;
   logic [31:0] reg1_i, reg2_i, offset_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o, mem_addr_o, mem_data_o;
   logic [6:0]  mem_opcode_o;
   logic [2:0]  mem_funct3_o;
   logic        stallreq_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic [6:0]  mop;
      logic [2:0]  mf3;
      logic [31:0] maddr;
      logic [31:0] mdata;
   } exp_t;

   ex_stage #(.SHIFT_STEP(8)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .stall_sign(stall_sign),
      .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .offset_i(offset_i),
      .wd_i(wd_i), .wreg_i(wreg_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .mem_opcode_o(mem_opcode_o), .mem_funct3_o(mem_funct3_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] off, input logic [4:0] wd, input logic wr);
      exp_t e;
      int   n;
      n = b[4:0];
      e = '0;
      e.wd = wd;
      e.wreg = wr;
      if (op == T_OP || op == T_OPI) begin
         case (f3)
            3'd0: e.wdata = (op == T_OP && f7[5]) ? a - b : a + b;
            3'd1: e.wdata = a << n;
            3'd2: e.wdata = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: e.wdata = ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
            3'd4: e.wdata = a ^ b;
            3'd5: begin
               e.wdata = a >> n;
               if (f7[5] && a[31] && n != 0) e.wdata = e.wdata | ~(32'hFFFF_FFFF >> n);
            end
            3'd6: e.wdata = a | b;
            default: e.wdata = a & b;
         endcase
      end else if (op == T_LUI) e.wdata = b;
      else if (op == T_JAL || op == T_JALR || op == T_AUIPC) e.wdata = a + b;
      else if (op == T_BR) e.wreg = 1'b0;
      else if (op == T_LOAD || op == T_STORE) begin
         e.mop = op;
         e.mf3 = f3;
         e.maddr = 32'((64'(a) + 64'(off)) % 64'h1_0000_0000);
         e.mdata = b;
      end
      return e;
   endfunction

   task automatic check_out(input string t, input exp_t e);
      check({t, ".wd"}, 32'(wd_o), 32'(e.wd));
      check({t, ".wreg"}, 32'(wreg_o), 32'(e.wreg));
      check({t, ".wdata"}, wdata_o, e.wdata);
      check({t, ".mem_op"}, 32'(mem_opcode_o), 32'(e.mop));
      check({t, ".mem_f3"}, 32'(mem_funct3_o), 32'(e.mf3));
      check({t, ".mem_addr"}, mem_addr_o, e.maddr);
      check({t, ".mem_data"}, mem_data_o, e.mdata);
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] off,
                        input logic [4:0] wd, input logic wr);
      opcode_i = op; funct3_i = f3; funct7_i = f7;
      reg1_i = a; reg2_i = b; offset_i = off; wd_i = wd; wreg_i = wr;
   endtask

   // Called just after a rising edge; returns just after the edge that retires the instruction.
   task automatic run_instr(input string t, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] off, input logic [4:0] wd, input logic wr,
                            input int hold, input bit rnd_rdy, output logic [31:0] got, output int stalls);
      exp_t e;
      int   frozen, want;
      drive(op, f3, f7, a, b, off, wd, wr);
      stall_sign = (hold > 0) ? 6'b001000 : 6'b000000;
      e = model(op, f3, f7, a, b, off, wd, wr);
      want = 0;
`ifndef EX_BARREL_SHIFT_EN
      if ((op == T_OP || op == T_OPI) && (f3 == 3'd1 || f3 == 3'd5) && b[4:0] != 5'd0)
         want = (int'(b[4:0]) + 7) / 8 + 1;
`endif
      stalls = 0;
      frozen = 0;
      @(negedge clk);
      while (stallreq_o === 1'b1 && stalls < 60) begin
         stalls++;
         rdy = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
         if (!rdy) frozen++;
         @(negedge clk);
      end
      rdy = 1'b1;
      check({t, ".stall_cycles"}, 32'(stalls), 32'(want + frozen));
      check_out(t, e);
      got = wdata_o;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({t, ".hold_wdata"}, wdata_o, e.wdata);
         check({t, ".hold_stall"}, 32'(stallreq_o), 32'd0);
      end
      stall_sign = 6'b000000;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] got;
   int          stalls;
   logic [6:0]  ops [10] = '{T_OP, T_OPI, T_LOAD, T_STORE, T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_BAD};

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      stall_sign = '0;
      drive(T_STORE, 3'd2, 7'h20, 32'h1234_5678, 32'h9ABC_DEF0, 32'h10, 5'd9, 1'b1);
      @(negedge clk);
      check("rst.wd", 32'(wd_o), 32'd0);
      check("rst.wreg", 32'(wreg_o), 32'd0);
      check("rst.wdata", wdata_o, 32'd0);
      check("rst.mem_op", 32'(mem_opcode_o), 32'd0);
      check("rst.mem_f3", 32'(mem_funct3_o), 32'd0);
      check("rst.mem_addr", mem_addr_o, 32'd0);
      check("rst.mem_data", mem_data_o, 32'd0);
      check("rst.stall", 32'(stallreq_o), 32'd0);
      drive(T_OP, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_instr("add", T_OP, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd5, 1'b1, 0, 1'b0, got, stalls);
      check("add.const", got, 32'h8000_0000);
      check("add.nostall", 32'(stalls), 32'd0);

      run_instr("sra31", T_OPI, 3'd5, 7'h20, 32'h8000_0000, 32'd31, 32'd0, 5'd7, 1'b1, 0, 1'b0, got, stalls);
      check("sra31.const", got, 32'hFFFF_FFFF);
`ifndef EX_BARREL_SHIFT_EN
      check("sra31.stall5", 32'(stalls), 32'd5);
`endif

      run_instr("sll0", T_OP, 3'd1, 7'h00, 32'd1, 32'd0, 32'd0, 5'd3, 1'b1, 0, 1'b0, got, stalls);
      check("sll0.const", got, 32'd1);
      check("sll0.nostall", 32'(stalls), 32'd0);

      run_instr("srl_hold", T_OPI, 3'd5, 7'h00, 32'hF000_0000, 32'd4, 32'd0, 5'd4, 1'b1, 3, 1'b0, got, stalls);
      check("srl_hold.const", got, 32'h0F00_0000);

      run_instr("store", T_STORE, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hA5, 32'd8, 5'd0, 1'b0, 0, 1'b0, got, stalls);
      check("store.addr", mem_addr_o, 32'h0000_0004);

      drive(T_OP, 3'd1, 7'h00, 32'h0000_0003, 32'd20, 32'd0, 5'd6, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_mid.wdata", wdata_o, 32'd0);
      check("rst_mid.wd", 32'(wd_o), 32'd0);
      check("rst_mid.wreg", 32'(wreg_o), 32'd0);
      check("rst_mid.stall", 32'(stallreq_o), 32'd0);
      drive(T_OP, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_instr("add_after_rst", T_OP, 3'd0, 7'h00, 32'd100, 32'd23, 32'd0, 5'd11, 1'b1, 0, 1'b0, got, stalls);
      check("add_after_rst.const", got, 32'd123);

      for (int k = 0; k < 250; k++) begin
         logic [6:0]  op;
         logic [6:0]  f7;
         op = ops[$urandom_range(9)];
         f7 = ($urandom_range(1) != 0) ? 7'h20 : 7'h00;
         run_instr("rand", op, 3'($urandom_range(7)), f7, $urandom, $urandom, $urandom,
                   5'($urandom_range(31)), 1'($urandom_range(1)),
                   ($urandom_range(3) == 0) ? int'($urandom_range(1, 2)) : 0, 1'b1, got, stalls);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
